// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: access sequencer states
// and the grant identifier latched for the access in flight.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_RESPOND = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_GRANT_INST = 1'b0,
    ARB_GRANT_DATA = 1'b1
  } arb_grant_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Each access runs IDLE -> ACCESS -> RESPOND; data has priority, bounded by a fetch starvation limit.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STREAK_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic                    inst_ack,
  output logic [DATA_WIDTH-1:0]   inst_data,
  input  logic                    data_req,
  input  logic                    data_write_enable,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_byte_select,
  output logic                    data_ack,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    mem_chip_enable,
  output logic                    mem_write_enable,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_select,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall_request
);

  localparam int BSW = DATA_WIDTH / 8;
  localparam int SW  = $clog2(STREAK_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STREAK_LIMIT);

  arb_state_e             state_q, state_d;
  arb_grant_e             winner_q, winner_d;
  logic [SW-1:0]          streak_q, streak_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [BSW-1:0]         mem_be_q, mem_be_d;
  logic                   mem_we_q, mem_we_d;
  logic                   inst_ack_q, inst_ack_d;
  logic                   data_ack_q, data_ack_d;
  logic                   grant_data_s;

  // Data wins unless a waiting fetch has already been passed over STREAK_LIMIT times.
  assign grant_data_s = data_req & ~(inst_req & (streak_q == STREAK_MAX));

  // Next-state, grant latching and streak bookkeeping.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    streak_d    = streak_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    inst_ack_d  = 1'b0;
    data_ack_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (inst_req | data_req) begin
          state_d = ARB_ACCESS;
          if (grant_data_s) begin
            winner_d    = ARB_GRANT_DATA;
            mem_addr_d  = data_addr;
            mem_wdata_d = data_wdata;
            mem_be_d    = data_byte_select;
            mem_we_d    = data_write_enable;
            streak_d    = inst_req ? (streak_q + SW'(1)) : '0;
          end else begin
            winner_d    = ARB_GRANT_INST;
            mem_addr_d  = inst_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
            mem_we_d    = 1'b0;
            streak_d    = '0;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ACCESS: begin
        state_d    = ARB_RESPOND;
        inst_ack_d = (winner_q == ARB_GRANT_INST);
        data_ack_d = (winner_q == ARB_GRANT_DATA);
      end
      ARB_RESPOND: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      winner_q    <= ARB_GRANT_INST;
      streak_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      inst_ack_q  <= 1'b0;
      data_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      streak_q    <= streak_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      inst_ack_q  <= inst_ack_d;
      data_ack_q  <= data_ack_d;
    end
  end

  // Gating with ~reset keeps a reset in ACCESS from committing a write and in RESPOND from acking.
  assign mem_chip_enable  = (state_q == ARB_ACCESS) & ~reset;
  assign mem_write_enable = mem_chip_enable & mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign mem_byte_select  = mem_be_q;

  assign inst_ack   = inst_ack_q & ~reset;
  assign data_ack   = data_ack_q & ~reset;
  assign inst_data  = inst_ack ? mem_rdata : '0;
  assign data_rdata = data_ack ? mem_rdata : '0;

  assign stall_request = (inst_req & ~inst_ack) | (data_req & ~data_ack);

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-lane memory model behind it.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_data;
  logic        data_req;
  logic        data_write_enable;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_byte_select;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        mem_chip_enable;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_select;
  logic [31:0] mem_rdata;
  logic        stall_request;

  logic [31:0] mem [0:255];
  logic        mem_init;
  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STREAK_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_data(inst_data),
    .data_req(data_req), .data_write_enable(data_write_enable), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_byte_select(data_byte_select),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_chip_enable(mem_chip_enable), .mem_write_enable(mem_write_enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_select(mem_byte_select),
    .mem_rdata(mem_rdata), .stall_request(stall_request)
  );

  always #5 clock = ~clock;

  // Synchronous single-port memory: samples on the edge, data out next cycle.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'hA000_0000;
      mem[1]   <= 32'hA111_1111;
      mem[2]   <= 32'hA222_2222;
      mem[4]   <= 32'h2408_0005;
      mem[128] <= 32'h1234_5678;
      mem_rdata <= 32'h0;
    end else if (mem_chip_enable) begin
      for (int b = 0; b < 4; b++)
        if (mem_write_enable && mem_byte_select[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_write_enable = 1'b0; data_addr = 32'h0;
    data_wdata = 32'h0; data_byte_select = 4'h0;
    tick(); tick();
    reset = 1'b0; mem_init = 1'b0; #1;

    // reset state
    chk("rst_ce",    32'(mem_chip_enable), 32'h0);
    chk("rst_we",    32'(mem_write_enable), 32'h0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be",    32'(mem_byte_select), 32'h0);
    chk("rst_acks",  32'({inst_ack, data_ack}), 32'h0);
    chk("rst_stall", 32'(stall_request), 32'h0);

    // fetch alone
    inst_req = 1'b1; inst_addr = 32'h10; #1;
    chk("f_stall_n", 32'(stall_request), 32'h1);
    tick();
    chk("f_ce",      32'(mem_chip_enable), 32'h1);
    chk("f_we",      32'(mem_write_enable), 32'h0);
    chk("f_addr",    mem_addr, 32'h10);
    chk("f_be",      32'(mem_byte_select), 32'hf);
    chk("f_stall_1", 32'(stall_request), 32'h1);
    chk("f_ack_1",   32'(inst_ack), 32'h0);
    tick();
    chk("f_ce_off",  32'(mem_chip_enable), 32'h0);
    chk("f_ack",     32'(inst_ack), 32'h1);
    chk("f_data",    inst_data, 32'h2408_0005);
    chk("f_stall_2", 32'(stall_request), 32'h0);
    inst_req = 1'b0;
    tick();
    chk("f_ack_off", 32'(inst_ack), 32'h0);
    chk("f_data_0",  inst_data, 32'h0);

    // store then back-to-back load
    data_req = 1'b1; data_write_enable = 1'b1; data_addr = 32'h100;
    data_wdata = 32'hDEAD_BEEF; data_byte_select = 4'hf;
    tick();
    chk("st_ce",    32'(mem_chip_enable), 32'h1);
    chk("st_we",    32'(mem_write_enable), 32'h1);
    chk("st_addr",  mem_addr, 32'h100);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("st_ack",    32'(data_ack), 32'h1);
    chk("st_we_off", 32'(mem_write_enable), 32'h0);
    chk("st_mem",    mem[64], 32'hDEAD_BEEF);
    tick();
    chk("ld_ack_0", 32'(data_ack), 32'h0);
    data_write_enable = 1'b0;
    tick();
    chk("ld_we",    32'(mem_write_enable), 32'h0);
    chk("ld_ack_1", 32'(data_ack), 32'h0);
    tick();
    chk("ld_ack",   32'(data_ack), 32'h1);
    chk("ld_data",  data_rdata, 32'hDEAD_BEEF);
    data_req = 1'b0;
    tick();

    // simultaneous requests: data first, fetch at N+5
    inst_req = 1'b1; inst_addr = 32'h10; data_req = 1'b1; data_addr = 32'h100;
    tick();
    chk("sim_addr_d", mem_addr, 32'h100);
    tick();
    chk("sim_dack",   32'(data_ack), 32'h1);
    chk("sim_iack_0", 32'(inst_ack), 32'h0);
    chk("sim_ddata",  data_rdata, 32'hDEAD_BEEF);
    chk("sim_stall",  32'(stall_request), 32'h1);
    data_req = 1'b0;
    tick();
    chk("sim_iack_3", 32'(inst_ack), 32'h0);
    tick();
    chk("sim_addr_i", mem_addr, 32'h10);
    tick();
    chk("sim_iack",   32'(inst_ack), 32'h1);
    chk("sim_idata",  inst_data, 32'h2408_0005);
    inst_req = 1'b0;
    tick();

    // starvation bound: D,D,D,D,I,D
    inst_req = 1'b1; inst_addr = 32'h10; data_req = 1'b1; data_addr = 32'h100;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk($sformatf("stv_addr%0d", g), mem_addr, (g == 4) ? 32'h10 : 32'h100);
      if (g == 4) chk("stv_streak0", 32'(dut.streak_q), 32'h0);
      tick();
      chk($sformatf("stv_ack%0d", g), 32'({inst_ack, data_ack}), (g == 4) ? 32'h2 : 32'h1);
      if (g == 5) begin
        inst_req = 1'b0; data_req = 1'b0;
      end
      tick();
    end

    // reset during the ACCESS of a store
    data_req = 1'b1; data_write_enable = 1'b1; data_addr = 32'h200;
    data_wdata = 32'hCAFE_F00D; data_byte_select = 4'hf;
    tick();
    chk("rs_ce_pre", 32'(mem_chip_enable), 32'h1);
    reset = 1'b1; data_req = 1'b0; data_write_enable = 1'b0; #1;
    chk("rs_ce_gate", 32'(mem_chip_enable), 32'h0);
    chk("rs_we_gate", 32'(mem_write_enable), 32'h0);
    tick();
    reset = 1'b0; #1;
    chk("rs_outs", 32'({mem_chip_enable, mem_write_enable, inst_ack, data_ack, stall_request}), 32'h0);
    chk("rs_addr",  mem_addr, 32'h0);
    chk("rs_wdata", mem_wdata, 32'h0);
    chk("rs_be",    32'(mem_byte_select), 32'h0);
    chk("rs_rdata", data_rdata | inst_data, 32'h0);
    tick();
    chk("rs_noack", 32'(data_ack), 32'h0);
    chk("rs_mem",   mem[128], 32'h1234_5678);

    // back-to-back fetch 0x0, 0x4, 0x8
    inst_req = 1'b1; inst_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("b2b_addr%0d", k), mem_addr, 32'(k * 4));
      chk($sformatf("b2b_noack%0d", k), 32'(inst_ack), 32'h0);
      tick();
      chk($sformatf("b2b_ack%0d", k), 32'(inst_ack), 32'h1);
      chk($sformatf("b2b_data%0d", k), inst_data,
          (k == 0) ? 32'hA000_0000 : ((k == 1) ? 32'hA111_1111 : 32'hA222_2222));
      tick();
      inst_addr = 32'((k + 1) * 4);
      if (k == 2) inst_req = 1'b0;
      chk($sformatf("b2b_idle%0d", k), 32'(inst_ack), 32'h0);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and access sequencer that shares one single-port synchronous memory between the CPU's instruction-fetch port and its load/store port. It sits between the `mips` core and the memory in `machine`, replacing the direct fetch-to-ROM wiring. Each access runs through a fixed three-state sequence. Data accesses have priority, bounded by a starvation limit that protects instruction fetch. A stall request to the core is raised while any access is outstanding.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width of both ports and memory
- `DATA_WIDTH`, 32, data width
- `STREAK_LIMIT`, 4, max consecutive data grants while a fetch waits; legal range ≥1

Ports:
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `inst_req`  in  1  fetch request, held until `inst_ack`
- `inst_addr`  in  ADDR_WIDTH  fetch address, stable while `inst_req` is high
- `inst_ack`  out  1  one-cycle completion pulse
- `inst_data`  out  DATA_WIDTH  fetched word, valid only with `inst_ack`
- `data_req`  in  1  load/store request, held until `data_ack`
- `data_write_enable`  in  1  1 = store
- `data_addr`  in  ADDR_WIDTH  load/store address
- `data_wdata`  in  DATA_WIDTH  store data
- `data_byte_select`  in  DATA_WIDTH/8  byte lanes for a store
- `data_ack`  out  1  one-cycle completion pulse
- `data_rdata`  out  DATA_WIDTH  load data, valid only with `data_ack`
- `mem_chip_enable`  out  1  memory access strobe
- `mem_write_enable`  out  1  memory write strobe
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_byte_select`  out  DATA_WIDTH/8  memory byte lanes
- `mem_rdata`  in  DATA_WIDTH  memory read data; the memory samples on the edge and drives data in the next cycle
- `stall_request`  out  1  `(inst_req & ~inst_ack) | (data_req & ~data_ack)`, combinational

## Operation
- **States:**
  - `IDLE`: arbitrate.
  - `ACCESS`: memory strobes driven; the memory samples at the end of this cycle.
  - `RESPOND`: `mem_rdata` is valid and the winner is acked.
- **Transitions:**
  - `IDLE` → `ACCESS` when any request is high.
  - `ACCESS` → `RESPOND` unconditionally.
  - `RESPOND` → `IDLE` unconditionally.
- **Arbitration in IDLE:**
  - Data wins a simultaneous request unless `streak == STREAK_LIMIT`; in that case fetch wins.
  - On the transition to `ACCESS`, latch the winner's address, write data, write enable and byte select into the `mem_*` registers. Register the winner ID.
  - Fetch grants drive write enable 0 and byte select all-ones.
- **Streak counter (0..STREAK_LIMIT):**
  - Increments on a data grant while `inst_req` is high.
  - Clears on any fetch grant, and on a data grant while `inst_req` is low.
- **RESPOND:**
  - Assert the winner's ack.
  - Drive the winner's data output combinationally from `mem_rdata`.
  - A store's `data_rdata` is don't-care; the bench must not check it.
- A request still high in `IDLE` after its ack is a new request. This is back-to-back issue; the requester updates its address in the cycle after the ack.
- Request inputs are ignored outside `IDLE`. Dropping a request mid-access is illegal; the access still completes and still acks.

## Timing
- Latency: request sampled in `IDLE` at cycle N, ack in cycle N+2. Throughput is one access per 3 cycles.
- `mem_chip_enable` is high only in `ACCESS`. `mem_write_enable` is high only in the `ACCESS` of a store.
- Reset values: state `IDLE`, streak 0, all `mem_*` registers 0, both acks 0.
- The memory strobes are gated with `~reset`. Reset during `ACCESS` therefore commits no write, the next state is `IDLE`, and no ack is issued.
- Reset during `RESPOND` suppresses the ack.
- `inst_data` and `data_rdata` are 0 when their ack is low.

## Structure
- `utility/utility.v` gets the shared defines: `ARB_STATE_BUS`; `ARB_IDLE`, `ARB_ACCESS` and `ARB_RESPOND` encodings; `ARB_GRANT_INST` and `ARB_GRANT_DATA`; `BYTE_SEL_BUS`.
- Existing `INST_ADDR_BUS`/`INST_DATA_BUS` are reused for the widths at the `machine` level.
- The block is a single module with no sub-module. The FSM, streak counter and output registers are inline.
- `machine` instantiates `mem_arbiter` between `mips` and the memory.

## Test plan
- **Fetch alone:** `inst_req`=1, `inst_addr`=0x0000_0010, memory returns 0x2408_0005 → `mem_chip_enable` for 1 cycle with `mem_addr`=0x10; `inst_ack` at N+2 with `inst_data`=0x2408_0005; `stall_request` high for N..N+1.
- **Store then load:** store of 0xDEAD_BEEF to 0x100 with byte select 4'b1111 → `mem_write_enable` high exactly 1 cycle. A following load of 0x100 → `data_rdata`=0xDEAD_BEEF; the load is acked 3 cycles after the store's ack.
- **Simultaneous requests:** both requests high → data granted first and acked at N+2; fetch then granted in the next `IDLE` and acked at N+5.
- **Starvation bound:** `inst_req` and `data_req` held high for 5 data loads with `STREAK_LIMIT`=4 → grant order D,D,D,D,I,D; streak returns to 0 after the I grant.
- **Reset mid-access:** `reset` pulsed during the `ACCESS` of a store to 0x200 → memory contents at 0x200 unchanged, no `data_ack`, all outputs 0 the cycle after reset.
- **Back-to-back fetch:** `inst_req` held high with the address stepping 0x0, 0x4, 0x8 after each ack → acks at N+2, N+5, N+8 with the correct words.
